seq_det_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_match_cmp.sv | 22 ++
 rtl/seq_det_param.sv | 125 ++++++++++++
 tb/tb_seq_det_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable sequence detector.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL,
        ST_ARMED
    } state_t;

    localparam logic [31:0] DEF_PATTERN = 32'b0001_1101;
    localparam int unsigned DEF_LEN     = 5;
    localparam bit          DEF_OVERLAP = 1'b1;

    function automatic logic len_valid(input int unsigned len, input int unsigned max);
        return (len >= 1) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_match_cmp.sv
// Masked compare of the history window against the pattern, low `len` bits only.
module seq_det_match_cmp #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = (((window ^ pattern) & mask) == '0);
    end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial sequence detector (Mealy match + registered copy).
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned        RST_LEN     = DEF_LEN,
    parameter bit                 RST_OVERLAP = DEF_OVERLAP,
    localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               datain_valid,
    input  logic               datain,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               dataout,
    output logic               dataout_q,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count
);

    state_t             state, state_n;
    logic [MAX_LEN-1:0] hist, hist_n, pat_q, pat_n;
    logic [LEN_W-1:0]   fill, fill_n, fill_inc, len_q, len_n;
    logic               ovl_q, ovl_n, err_n;
    logic [MAX_LEN-1:0] window;
    logic               hit;

    assign window = {hist[MAX_LEN-2:0], datain};

    seq_det_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window  (window),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_FILL;
        else        state <= state_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist      <= '0;
            fill      <= '0;
            pat_q     <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= RST_OVERLAP;
            cfg_err   <= 1'b0;
            dataout_q <= 1'b0;
        end else begin
            hist      <= hist_n;
            fill      <= fill_n;
            pat_q     <= pat_n;
            len_q     <= len_n;
            ovl_q     <= ovl_n;
            cfg_err   <= err_n;
            dataout_q <= dataout;
        end
    end

    // Any load cycle (accepted or rejected) discards the incoming bit.
    always_comb begin
        dataout = datain_valid && !cfg_load && (state == ST_ARMED) && hit;
    end

    always_comb begin
        state_n  = state;
        hist_n   = hist;
        fill_n   = fill;
        pat_n    = pat_q;
        len_n    = len_q;
        ovl_n    = ovl_q;
        err_n    = 1'b0;
        fill_inc = (fill == len_q) ? fill : fill + LEN_W'(1);
        if (cfg_load) begin
            if (len_valid(32'(cfg_len), MAX_LEN)) begin
                pat_n   = cfg_pattern;
                len_n   = cfg_len;
                ovl_n   = cfg_overlap;
                hist_n  = '0;
                fill_n  = '0;
                state_n = (cfg_len == LEN_W'(1)) ? ST_ARMED : ST_FILL;
            end else begin
                err_n = 1'b1;
            end
        end else if (datain_valid) begin
            hist_n = window;
            if (dataout && !ovl_q) begin
                fill_n  = '0;
                state_n = (len_q == LEN_W'(1)) ? ST_ARMED : ST_FILL;
            end else begin
                fill_n  = fill_inc;
                state_n = (fill_inc >= len_q - LEN_W'(1)) ? ST_ARMED : ST_FILL;
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     cnt_q <= '0;
        else if (count_clr)             cnt_q <= '0;
        else if (dataout && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match_count = cnt_q;
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed, table-driven bench for seq_det_param (counter checks honour SEQ_DET_COUNT_EN).
module tb_seq_det_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               datain_valid = 1'b0;
    logic               datain = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               count_clr = 1'b0;
    logic               dataout, dataout_q, cfg_err;
    logic [CNT_W-1:0]   match_count;

    int n_chk  = 0;
    int n_pass = 0;

    seq_det_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .datain_valid (datain_valid),
        .datain       (datain),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .count_clr    (count_clr),
        .dataout      (dataout),
        .dataout_q    (dataout_q),
        .cfg_err      (cfg_err),
        .match_count  (match_count)
    );

    always #5 clock = ~clock;

    // One row = inputs held for one cycle plus the outputs expected before the next edge.
    typedef struct {
        bit         rst, v, d, ld;
        logic [3:0] len;
        logic [7:0] pat;
        bit         ovl, clr;
        bit         e_do, e_q, e_err;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, bit d, bit ld, logic [3:0] len, logic [7:0] pat,
                                bit ovl, bit clr, bit e_do, bit e_q, bit e_err, int e_cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.ld = ld; r.len = len; r.pat = pat;
        r.ovl = ovl; r.clr = clr; r.e_do = e_do; r.e_q = e_q; r.e_err = e_err; r.e_cnt = e_cnt;
        return r;
    endfunction

    function automatic vec_t rst_row();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t bit_row(bit d, bit e_do, bit e_q, int e_cnt);
        return mk(0, 1, d, 0, 0, 0, 0, 0, e_do, e_q, 0, e_cnt);
    endfunction

    function automatic vec_t idle_row(bit d, bit e_q, bit e_err, int e_cnt);
        return mk(0, 0, d, 0, 0, 0, 0, 0, 0, e_q, e_err, e_cnt);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic apply(input vec_t r, input string tag);
        int exp_cnt;
        @(posedge clock);
        #1;
        reset        = r.rst ? 1'b0 : 1'b1;
        datain_valid = r.v;
        datain       = r.d;
        cfg_load     = r.ld;
        cfg_len      = r.len;
        cfg_pattern  = r.pat;
        cfg_overlap  = r.ovl;
        count_clr    = r.clr;
        @(negedge clock);
`ifdef SEQ_DET_COUNT_EN
        exp_cnt = r.e_cnt;
`else
        exp_cnt = 0;
`endif
        chk({tag, ".dataout"},   int'(dataout),     int'(r.e_do));
        chk({tag, ".dataout_q"}, int'(dataout_q),   int'(r.e_q));
        chk({tag, ".cfg_err"},   int'(cfg_err),     int'(r.e_err));
        chk({tag, ".count"},     int'(match_count), exp_cnt);
    endtask

    initial begin
        bit b9[9];
        b9 = '{1, 1, 1, 0, 1, 1, 1, 0, 1};

        // Reset defaults (11101, len 5, overlap): matches on bits 5 and 9.
        tbl.push_back(rst_row());
        tbl.push_back(bit_row(1, 0, 0, 0));
        tbl.push_back(bit_row(1, 0, 0, 0));
        tbl.push_back(bit_row(1, 0, 0, 0));
        tbl.push_back(bit_row(0, 0, 0, 0));
        tbl.push_back(bit_row(1, 1, 0, 0));
        tbl.push_back(bit_row(1, 0, 1, 1));
        tbl.push_back(bit_row(1, 0, 0, 1));
        tbl.push_back(bit_row(0, 0, 0, 1));
        tbl.push_back(bit_row(1, 1, 0, 1));
        tbl.push_back(idle_row(0, 1, 0, 2));
        // Non-overlap load (with count clear); incoming bit on the load cycle is dropped.
        tbl.push_back(mk(0, 1, 1, 1, 5, 8'h1D, 0, 1, 0, 0, 0, 2));
        for (int i = 0; i < 9; i++)
            tbl.push_back(bit_row(b9[i], (i == 4), (i == 5), (i >= 5) ? 1 : 0));
        tbl.push_back(idle_row(0, 0, 0, 1));
        // Load 0110/len4/overlap, then two rejected loads; old config must survive.
        tbl.push_back(mk(0, 0, 0, 1, 4, 8'h06, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 9, 8'hFF, 0, 0, 0, 0, 1, 1));
        tbl.push_back(idle_row(0, 0, 1, 1));
        tbl.push_back(bit_row(0, 0, 0, 1));
        tbl.push_back(bit_row(1, 0, 0, 1));
        tbl.push_back(bit_row(1, 0, 0, 1));
        tbl.push_back(bit_row(0, 1, 0, 1));
        tbl.push_back(bit_row(1, 0, 1, 2));
        tbl.push_back(bit_row(1, 0, 0, 2));
        tbl.push_back(bit_row(0, 1, 0, 2));
        tbl.push_back(idle_row(0, 1, 0, 3));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Valid gaps: after bit 3, then after bit 4 while armed with datain=1 on the bus.
        apply(rst_row(), "gap.rst");
        for (int i = 0; i < 3; i++) apply(bit_row(1, 0, 0, 0), "gap.b");
        for (int i = 0; i < 3; i++) apply(idle_row(1, 0, 0, 0), "gap.idle3");
        apply(bit_row(0, 0, 0, 0), "gap.b4");
        for (int i = 0; i < 3; i++) apply(idle_row(1, 0, 0, 0), "gap.idle4");
        apply(bit_row(1, 1, 0, 0), "gap.b5");
        // Reset mid-cycle right after a match: registered outputs clear without an edge.
        apply(rst_row(), "gap.async_rst");

        // Len-1 pattern: every one matches; counter saturates, clear beats a match.
        apply(rst_row(), "sat.rst");
        apply(mk(0, 0, 0, 1, 1, 8'h01, 1, 0, 0, 0, 0, 0), "sat.load");
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            apply(bit_row(1, 1, (i > 0), (i > 255) ? 255 : i), $sformatf("sat.b%0d", i));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 255), "sat.clr_match");
        apply(idle_row(0, 1, 0, 0), "sat.after_clr");
        apply(bit_row(0, 0, 0, 0), "sat.zero");

        // Reset after 1,1,1,0: partial pattern must not complete.
        apply(rst_row(), "mid.rst0");
        apply(bit_row(1, 0, 0, 0), "mid.b1");
        apply(bit_row(1, 0, 0, 0), "mid.b2");
        apply(bit_row(1, 0, 0, 0), "mid.b3");
        apply(bit_row(0, 0, 0, 0), "mid.b4");
        apply(rst_row(), "mid.rst1");
        apply(bit_row(1, 0, 0, 0), "mid.after");
        apply(idle_row(0, 0, 0, 0), "mid.q");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
